mem_data_dumper: RTL and testbench

- Debug-side reader that drives the read port of memoria_datos and streams its contents to the UART tx, one byte at a time.
- On a start pulse it reads words 0..N-1 in order and splits each RAM_WIDTH-bit word into bytes, MSB byte first.
- Each byte is handed to the tx with a start/done handshake.
- Sits between memoria_datos and the tx module inside the debug unit.
- Never writes memory.

---
 rtl/mem_data_dumper_pkg.sv | 16 +
 rtl/mem_data_dumper_if.sv | 25 ++
 rtl/mem_data_dumper_word_byte_serializer.sv | 44 ++++
 rtl/mem_data_dumper.sv | 114 +++++++++++
 tb/tb_mem_data_dumper.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_data_dumper_pkg.sv
// Shared definitions for the memory dump path: FSM state encoding and byte width.
package mem_data_dumper_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_TX   = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } state_e;

endpackage

// File: rtl/mem_data_dumper_if.sv
// Memory read port and tx byte handshake between the dumper (master) and its peers.
interface mem_data_dumper_if
  import mem_data_dumper_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int RAM_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_regcea;
  logic                  o_mem_wea;
  logic [RAM_WIDTH-1:0]  i_mem_data;
  logic [BYTE_WIDTH-1:0] o_tx_data;
  logic                  o_tx_start;
  logic                  i_tx_done;

  modport master (
    output o_mem_addr, o_mem_regcea, o_mem_wea, o_tx_data, o_tx_start,
    input  i_mem_data, i_tx_done
  );

  modport slave (
    input  o_mem_addr, o_mem_regcea, o_mem_wea, o_tx_data, o_tx_start,
    output i_mem_data, i_tx_done
  );
endinterface

// File: rtl/mem_data_dumper_word_byte_serializer.sv
// Holds one captured memory word and walks it out MSB byte first.
module mem_data_dumper_word_byte_serializer
  import mem_data_dumper_pkg::*;
#(
  parameter int RAM_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [RAM_WIDTH-1:0]  i_word,
  input  logic                  i_advance,
  output logic [BYTE_WIDTH-1:0] o_byte,
  output logic                  o_last
);
  localparam int NB    = RAM_WIDTH / BYTE_WIDTH;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [NB-1:0][BYTE_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]              idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (i_load) begin
      word_d = i_word;
      idx_d  = IDX_W'(NB - 1);
    end else if (i_advance && (idx_q != '0)) begin
      idx_d = idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign o_byte = word_q[idx_q];
  assign o_last = (idx_q == '0);
endmodule

// File: rtl/mem_data_dumper.sv
// Reads words 0..len-1 from data memory and hands each byte, MSB first, to the UART tx.
// Memory is never written; a dump is abandoned immediately on reset.
module mem_data_dumper
  import mem_data_dumper_pkg::*;
#(
  parameter int RAM_WIDTH    = 16,
  parameter int RAM_DEPTH    = 1024,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_word_count,
  output logic                  o_busy,
  output logic                  o_done,
  mem_data_dumper_if.master     bus
);
  localparam int LEN_W = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [1:0]            wait_q, wait_d;
  logic [LEN_W-1:0]      req_len;
  logic                  load, advance, last_byte;

  // Length is one bit wider than the address so RAM_DEPTH = 2**ADDR_WIDTH still fits.
  assign req_len = ({1'b0, i_word_count} > LEN_W'(RAM_DEPTH)) ? LEN_W'(RAM_DEPTH)
                                                              : {1'b0, i_word_count};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wait_d  = wait_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          len_d   = req_len;
          addr_d  = '0;
          state_d = (req_len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        wait_d  = '0;
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (wait_q == 2'(READ_LATENCY - 1)) begin
          load    = 1'b1;
          state_d = S_SEND;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_SEND: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (bus.i_tx_done) begin
          if (last_byte) begin
            state_d = S_NEXT;
          end else begin
            advance = 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_NEXT: begin
        // The address stops at len-1 rather than stepping past the last word.
        if (({1'b0, addr_q} + LEN_W'(1)) == len_q) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wait_q  <= wait_d;
    end
  end

  mem_data_dumper_word_byte_serializer #(.RAM_WIDTH(RAM_WIDTH)) u_word_byte_serializer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (load),
    .i_word    (bus.i_mem_data),
    .i_advance (advance),
    .o_byte    (bus.o_tx_data),
    .o_last    (last_byte)
  );

  assign bus.o_mem_addr   = addr_q;
  assign bus.o_mem_regcea = (state_q == S_READ) || (state_q == S_WAIT_DATA);
  assign bus.o_mem_wea    = 1'b0;
  assign bus.o_tx_start   = (state_q == S_SEND);
  assign o_busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done           = (state_q == S_DONE);
endmodule

// File: tb/tb_mem_data_dumper.sv
// Directed bench: byte scoreboard for a READ_LATENCY=1 dumper plus a hand-timed READ_LATENCY=2 instance.
module tb_mem_data_dumper;
  logic        clk = 1'b0;
  logic        rst, start, start2, busy, done, busy2, done2;
  logic [15:0] wcount, wcount2;
  logic [15:0] mem [0:1023];
  logic [15:0] rd1, mem2_dat;
  logic        tx_done1 = 1'b0;
  logic        tx_done2;

  int cyc = 0;
  int vecs = 0;
  int errs = 0;
  int n_tx = 0, done_cnt = 0, done_cyc = 0, first_tx_cyc = -1, last_txdone_cyc = 0;
  int start_cyc = 0, tx_dly = 10, tx_cnt = 0, max_addr = -1;
  logic wea_seen = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] q2 [$];

  always #5 clk = ~clk;

  mem_data_dumper_if #(.ADDR_WIDTH(16), .RAM_WIDTH(16)) bus1 ();
  mem_data_dumper_if #(.ADDR_WIDTH(16), .RAM_WIDTH(16)) bus2 ();

  mem_data_dumper #(.RAM_WIDTH(16), .RAM_DEPTH(1024), .ADDR_WIDTH(16), .READ_LATENCY(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_word_count(wcount),
    .o_busy(busy), .o_done(done), .bus(bus1)
  );

  mem_data_dumper #(.RAM_WIDTH(16), .RAM_DEPTH(1024), .ADDR_WIDTH(16), .READ_LATENCY(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_start(start2), .i_word_count(wcount2),
    .o_busy(busy2), .o_done(done2), .bus(bus2)
  );

  assign bus1.i_mem_data = rd1;
  assign bus1.i_tx_done  = tx_done1;
  assign bus2.i_mem_data = mem2_dat;
  assign bus2.i_tx_done  = tx_done2;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus1.o_mem_regcea) rd1 <= mem[bus1.o_mem_addr[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor and tx model for the latency-1 instance.
  always @(negedge clk) begin
    tx_done1 = 1'b0;
    if (tx_cnt != 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done1 = 1'b1;
        last_txdone_cyc = cyc;
      end
    end
    if (bus1.o_tx_start) begin
      tx_cnt = tx_dly;
      n_tx++;
      if (first_tx_cyc < 0) first_tx_cyc = cyc;
      check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("tx_byte", 32'(bus1.o_tx_data), 32'(exp_q.pop_front()));
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus1.o_mem_regcea && (int'(bus1.o_mem_addr) > max_addr)) max_addr = int'(bus1.o_mem_addr);
    if (bus1.o_mem_wea || bus2.o_mem_wea) wea_seen = 1'b1;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic kick(input logic [15:0] n);
    start = 1'b1;
    wcount = n;
    start_cyc = cyc;
    first_tx_cyc = -1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget, input string tag);
    int k = 0;
    while (done_cnt == n0 && k < budget) begin
      step();
      k++;
    end
    repeat (3) step();
    check(tag, 32'(done_cnt), 32'(n0 + 1));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_addr"},   32'(bus1.o_mem_addr),   32'd0);
    check({tag, "_regcea"}, 32'(bus1.o_mem_regcea), 32'd0);
    check({tag, "_wea"},    32'(bus1.o_mem_wea),    32'd0);
    check({tag, "_txdata"}, 32'(bus1.o_tx_data),    32'd0);
    check({tag, "_txstart"},32'(bus1.o_tx_start),   32'd0);
    check({tag, "_busy"},   32'(busy),              32'd0);
    check({tag, "_done"},   32'(done),              32'd0);
  endtask

  initial begin
    int n0, ntx0, k;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; wcount = '0; wcount2 = '0;
    tx_done2 = 1'b0; mem2_dat = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset held three cycles, then idle.
    repeat (3) step();
    check_idle("rst_hold");
    rst = 1'b0;
    step();
    check_idle("idle");
    check("idle2_busy", 32'(busy2), 32'd0);
    check("idle2_txstart", 32'(bus2.o_tx_start), 32'd0);

    // Single word 0x000F.
    mem[0] = 16'h000F;
    exp_q.push_back(8'h00); exp_q.push_back(8'h0F);
    n0 = done_cnt;
    kick(16'd1);
    check("single_busy", 32'(busy), 32'd1);
    wait_done(n0, 200, "single_done");
    check("single_first_lat", 32'(first_tx_cyc - start_cyc), 32'd3);
    check("single_done_lat", 32'(done_cyc - last_txdone_cyc), 32'd2);
    check("single_q_empty", 32'(exp_q.size()), 32'd0);
    check("single_busy_end", 32'(busy), 32'd0);

    // Three words with a stray start mid-dump.
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h8086;
    foreach (mem[i]) if (i < 3) begin
      exp_q.push_back(mem[i][15:8]);
      exp_q.push_back(mem[i][7:0]);
    end
    n0 = done_cnt; ntx0 = n_tx; max_addr = -1;
    kick(16'd3);
    repeat (15) step();
    start = 1'b1; wcount = 16'd5;
    step();
    start = 1'b0;
    wait_done(n0, 400, "multi_done");
    check("multi_max_addr", 32'(max_addr), 32'd2);
    check("multi_ntx", 32'(n_tx - ntx0), 32'd6);
    check("multi_q_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length dump.
    n0 = done_cnt; ntx0 = n_tx;
    kick(16'd0);
    check("zero_done_pulse", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    repeat (5) step();
    check("zero_ntx", 32'(n_tx - ntx0), 32'd0);
    check("zero_done_cnt", 32'(done_cnt), 32'(n0 + 1));

    // Oversized count clamps to RAM_DEPTH.
    tx_dly = 2;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'(i * 37 + 5);
      exp_q.push_back(mem[i][15:8]);
      exp_q.push_back(mem[i][7:0]);
    end
    n0 = done_cnt; ntx0 = n_tx; max_addr = -1;
    kick(16'd2000);
    wait_done(n0, 20000, "clamp_done");
    check("clamp_ntx", 32'(n_tx - ntx0), 32'd2048);
    check("clamp_max_addr", 32'(max_addr), 32'd1023);
    check("clamp_q_empty", 32'(exp_q.size()), 32'd0);
    tx_dly = 10;

    // Reset while waiting on the second byte, then restart.
    mem[0] = 16'h1234; mem[1] = 16'h5678;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    n0 = done_cnt; ntx0 = n_tx;
    kick(16'd2);
    k = 0;
    while (n_tx < ntx0 + 2 && k < 100) begin
      step();
      k++;
    end
    check("abort_reached_byte2", 32'(n_tx - ntx0), 32'd2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("abort");
    repeat (30) step();
    check("abort_no_tx", 32'(n_tx - ntx0), 32'd2);
    check("abort_no_done", 32'(done_cnt), 32'(n0));
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    ntx0 = n_tx;
    kick(16'd2);
    wait_done(n0, 400, "restart_done");
    check("restart_first_lat", 32'(first_tx_cyc - start_cyc), 32'd3);
    check("restart_ntx", 32'(n_tx - ntx0), 32'd4);
    check("restart_q_empty", 32'(exp_q.size()), 32'd0);

    // READ_LATENCY=2: capture on the second wait cycle, data changes around it.
    q2.push_back(8'hA5); q2.push_back(8'h5A);
    mem2_dat = 16'h1234;
    start2 = 1'b1; wcount2 = 16'd1;
    step();                                       // READ
    start2 = 1'b0;
    step();                                       // first wait cycle
    check("rl2_regcea", 32'(bus2.o_mem_regcea), 32'd1);
    step();                                       // capture cycle
    mem2_dat = 16'hA55A;
    step();                                       // SEND, four cycles after start
    mem2_dat = 16'hFFFF;
    check("rl2_first_start", 32'(bus2.o_tx_start), 32'd1);
    check("rl2_byte0", 32'(bus2.o_tx_data), 32'(q2.pop_front()));
    check("rl2_regcea_off", 32'(bus2.o_mem_regcea), 32'd0);
    tx_done2 = 1'b1;                              // coincides with tx start: ignored
    step();
    tx_done2 = 1'b0;
    check("rl2_early_done_ignored", 32'(bus2.o_tx_start), 32'd0);
    check("rl2_hold", 32'(bus2.o_tx_data), 32'h0A5);
    step();
    tx_done2 = 1'b1;
    step();
    tx_done2 = 1'b0;
    check("rl2_second_start", 32'(bus2.o_tx_start), 32'd1);
    check("rl2_byte1", 32'(bus2.o_tx_data), 32'(q2.pop_front()));
    step();
    tx_done2 = 1'b1;
    step();
    tx_done2 = 1'b0;
    check("rl2_next_no_done", 32'(done2), 32'd0);
    check("rl2_next_busy", 32'(busy2), 32'd1);
    step();
    check("rl2_done", 32'(done2), 32'd1);
    check("rl2_done_busy", 32'(busy2), 32'd0);
    step();
    check("rl2_done_once", 32'(done2), 32'd0);

    check("wea_never", 32'(wea_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
